// File: rtl/ascon_fsm_pkg.sv
// Shared types and constants for the ASCON-128 encryption controller.
// Round indices are the core's own numbering: p12 runs 0..11, p6 runs 6..11.
package ascon_pack;

   typedef enum logic [3:0] {
      S_IDLE,
      S_INIT,
      S_WAIT_AD,
      S_AD,
      S_WAIT_PT,
      S_PT,
      S_FINAL,
      S_TAG,
      S_DONE
   } fsm_state_t;

   localparam logic [3:0]  ROUND_P12_FIRST = 4'd0;
   localparam logic [3:0]  ROUND_P6_FIRST  = 4'd6;
   localparam logic [3:0]  ROUND_LAST      = 4'd11;
   localparam int unsigned NB_PT_BLOCKS    = 3;
   localparam logic [1:0]  LAST_PT_BLOCK   = 2'(NB_PT_BLOCKS - 1);

endpackage

// File: rtl/ascon_fsm_round_counter.sv
// Round index counter for the permutation core: loads the first round of
// a p12 or p6 sweep, then steps one round per enabled cycle.
module round_counter
   import ascon_pack::*;
(
   input  logic       clock_i,
   input  logic       resetb_i,
   input  logic       load_i,
   input  logic       load_p6_i,
   input  logic       inc_i,
   output logic [3:0] count_o,
   output logic       last_o
);

   logic [3:0] r_count;
   logic [3:0] w_load_value;

   assign w_load_value = load_p6_i ? ROUND_P6_FIRST : ROUND_P12_FIRST;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process evaluation order.
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         r_count <= ROUND_P12_FIRST;
      end else if (load_i) begin
         r_count <= w_load_value;
      end else if (inc_i) begin
         r_count <= r_count + 4'd1;
      end
   end

   assign count_o = r_count;
   assign last_o  = (r_count == ROUND_LAST);

endmodule

// File: rtl/ascon_fsm.sv
// ASCON-128 encryption controller: sequences init, one AD block, three
// plaintext blocks and finalisation, one permutation round per clock.
module ascon_fsm
   import ascon_pack::*;
(
   input  logic       clock_i,
   input  logic       resetb_i,
   input  logic       start_i,
   input  logic       data_valid_i,
   output logic       data_ready_o,
   output logic [3:0] round_o,
   output logic       state_mode_o,
   output logic       en_reg_state_o,
   output logic       en_xor_data_o,
   output logic       en_xor_key_begin_o,
   output logic       en_xor_key_end_o,
   output logic       en_xor_lsb_o,
   output logic       en_cipher_o,
   output logic       en_tag_o,
   output logic       cipher_valid_o,
   output logic       end_o
);

   fsm_state_t r_state;
   fsm_state_t w_next;
   logic [1:0] r_blk;
   logic       r_cipher_valid;
   logic [3:0] w_count;
   logic       w_last;
   logic       w_cnt_load;
   logic       w_cnt_load_p6;
   logic       w_cnt_inc;
   logic       w_blk_clr;
   logic       w_blk_inc;

   round_counter u_round_counter (
      .clock_i   (clock_i),
      .resetb_i  (resetb_i),
      .load_i    (w_cnt_load),
      .load_p6_i (w_cnt_load_p6),
      .inc_i     (w_cnt_inc),
      .count_o   (w_count),
      .last_o    (w_last)
   );

   // NOTE: every signal gets a default before the case so no path leaves a
   // value unassigned, which would otherwise infer a latch.
   always_comb begin
      w_next             = r_state;
      w_cnt_load         = 1'b0;
      w_cnt_load_p6      = 1'b0;
      w_cnt_inc          = 1'b0;
      w_blk_clr          = 1'b0;
      w_blk_inc          = 1'b0;
      data_ready_o       = 1'b0;
      round_o            = 4'd0;
      state_mode_o       = 1'b0;
      en_reg_state_o     = 1'b0;
      en_xor_data_o      = 1'b0;
      en_xor_key_begin_o = 1'b0;
      en_xor_key_end_o   = 1'b0;
      en_xor_lsb_o       = 1'b0;
      en_cipher_o        = 1'b0;
      en_tag_o           = 1'b0;
      end_o              = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            end_o = (r_state == S_DONE);
            if (start_i) begin
               w_next     = S_INIT;
               w_cnt_load = 1'b1;
               w_blk_clr  = 1'b1;
            end
         end
         S_INIT: begin
            round_o        = w_count;
            state_mode_o   = (w_count != ROUND_P12_FIRST);
            en_reg_state_o = 1'b1;
            if (w_last) begin
               en_xor_key_end_o = 1'b1;
               w_next           = S_WAIT_AD;
               w_cnt_load       = 1'b1;
               w_cnt_load_p6    = 1'b1;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         // The counter already holds the phase's first round while waiting,
         // so the handshake cycle simply exposes it.
         S_WAIT_AD: begin
            data_ready_o = 1'b1;
            if (data_valid_i) begin
               round_o        = w_count;
               state_mode_o   = 1'b1;
               en_reg_state_o = 1'b1;
               en_xor_data_o  = 1'b1;
               w_cnt_inc      = 1'b1;
               w_next         = S_AD;
            end
         end
         S_AD: begin
            round_o        = w_count;
            state_mode_o   = 1'b1;
            en_reg_state_o = 1'b1;
            if (w_last) begin
               en_xor_lsb_o  = 1'b1;
               w_next        = S_WAIT_PT;
               w_cnt_load    = 1'b1;
               w_cnt_load_p6 = 1'b1;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         S_WAIT_PT: begin
            data_ready_o = 1'b1;
            if (data_valid_i) begin
               round_o        = w_count;
               state_mode_o   = 1'b1;
               en_reg_state_o = 1'b1;
               en_xor_data_o  = 1'b1;
               en_cipher_o    = 1'b1;
               w_cnt_inc      = 1'b1;
               if (r_blk == LAST_PT_BLOCK) begin
                  en_xor_key_begin_o = 1'b1;
                  w_next             = S_FINAL;
               end else begin
                  w_next = S_PT;
               end
            end
         end
         S_PT: begin
            round_o        = w_count;
            state_mode_o   = 1'b1;
            en_reg_state_o = 1'b1;
            if (w_last) begin
               w_blk_inc     = 1'b1;
               w_next        = S_WAIT_PT;
               w_cnt_load    = 1'b1;
               // The last plaintext block merges into the p12 finalisation.
               w_cnt_load_p6 = (r_blk != LAST_PT_BLOCK - 2'd1);
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         S_FINAL: begin
            round_o        = w_count;
            state_mode_o   = 1'b1;
            en_reg_state_o = 1'b1;
            if (w_last) begin
               en_xor_key_end_o = 1'b1;
               w_next           = S_TAG;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         S_TAG: begin
            en_tag_o = 1'b1;
            w_next   = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         r_state        <= S_IDLE;
         r_blk          <= 2'd0;
         r_cipher_valid <= 1'b0;
      end else begin
         r_state        <= w_next;
         r_cipher_valid <= en_cipher_o;
         if (w_blk_clr) begin
            r_blk <= 2'd0;
         end else if (w_blk_inc) begin
            r_blk <= r_blk + 2'd1;
         end
      end
   end

   assign cipher_valid_o = r_cipher_valid;

endmodule

// File: tb/tb_ascon_fsm.sv
// Self-checking bench for ascon_fsm: table checks on a nominal run plus
// randomized handshake runs against a schedule-based reference model.
module tb_ascon_fsm;

   typedef struct packed {
      logic       ready;
      logic [3:0] rnd;
      logic       mode;
      logic       en_reg;
      logic       xd;
      logic       kb;
      logic       ke;
      logic       lsb;
      logic       ciph;
      logic       tag;
      logic       cv;
      logic       endo;
   } out_t;

   typedef struct {
      int         off;
      logic [3:0] rnd;
      logic       mode;
      logic       ready;
      logic       ke;
      logic       lsb;
      logic       kb;
      logic       cv;
      logic       tag;
      logic       endo;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       valid = 1'b0;
   logic       data_ready, state_mode, en_reg_state, en_xor_data;
   logic       en_xor_key_begin, en_xor_key_end, en_xor_lsb;
   logic       en_cipher, en_tag, cipher_valid, end_sig;
   logic [3:0] round_idx;
   out_t       dut_o;

   int         n_checks = 0;
   int         n_fails  = 0;
   out_t       ev[$];
   bit         hs[$];
   out_t       tr[0:255];
   bit         in_done = 1'b0;
   logic       prev_ciph = 1'b0;
   vec_t       vecs[$];

   always #5 clk = ~clk;

   ascon_fsm dut (
      .clock_i            (clk),
      .resetb_i           (rst_n),
      .start_i            (start),
      .data_valid_i       (valid),
      .data_ready_o       (data_ready),
      .round_o            (round_idx),
      .state_mode_o       (state_mode),
      .en_reg_state_o     (en_reg_state),
      .en_xor_data_o      (en_xor_data),
      .en_xor_key_begin_o (en_xor_key_begin),
      .en_xor_key_end_o   (en_xor_key_end),
      .en_xor_lsb_o       (en_xor_lsb),
      .en_cipher_o        (en_cipher),
      .en_tag_o           (en_tag),
      .cipher_valid_o     (cipher_valid),
      .end_o              (end_sig)
   );

   assign dut_o = {data_ready, round_idx, state_mode, en_reg_state, en_xor_data,
                   en_xor_key_begin, en_xor_key_end, en_xor_lsb, en_cipher,
                   en_tag, cipher_valid, end_sig};

   task automatic check_out(input string name, input out_t act, input out_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic out_t round_ev(input logic [3:0] r);
      out_t e;
      e        = '0;
      e.rnd    = r;
      e.mode   = 1'b1;
      e.en_reg = 1'b1;
      return e;
   endfunction

   // Expected schedule: one record per round cycle, handshake cycles flagged.
   task automatic build_events();
      out_t e;
      for (int r = 0; r < 12; r++) begin
         e      = round_ev(4'(r));
         e.mode = (r != 0);
         e.ke   = (r == 11);
         ev.push_back(e); hs.push_back(1'b0);
      end
      for (int blk = 0; blk < 4; blk++) begin
         e       = round_ev((blk == 3) ? 4'd0 : 4'd6);
         e.ready = 1'b1;
         e.xd    = 1'b1;
         e.ciph  = (blk != 0);
         e.kb    = (blk == 3);
         ev.push_back(e); hs.push_back(1'b1);
         for (int r = ((blk == 3) ? 1 : 7); r < 12; r++) begin
            e     = round_ev(4'(r));
            e.lsb = (blk == 0 && r == 11);
            e.ke  = (blk == 3 && r == 11);
            ev.push_back(e); hs.push_back(1'b0);
         end
      end
      e     = '0;
      e.tag = 1'b1;
      ev.push_back(e); hs.push_back(1'b0);
   endtask

   task automatic run_enc(input int pct, input int hold_ad, input int abort_off,
                          input bit noise, output int t_end);
      int   idx;
      int   held;
      int   off;
      bit   fin;
      out_t exp;
      logic v;
      idx = 0; held = 0; off = 0; fin = 1'b0; t_end = -1;
      @(posedge clk); #1;
      start = 1'b1;
      valid = 1'($urandom);
      exp      = '0;
      exp.endo = in_done;
      exp.cv   = prev_ciph;
      prev_ciph = 1'b0;
      @(negedge clk);
      check_out("start_cycle", dut_o, exp);
      tr[0] = dut_o;
      while (!fin) begin
         off++;
         @(posedge clk); #1;
         start = (noise && idx < ev.size()) ? ($urandom_range(9) == 0) : 1'b0;
         if (idx == 12 && held < hold_ad) begin
            v = 1'b0;
            held++;
         end else begin
            v = ($urandom_range(99) < 32'(pct));
         end
         valid = v;
         if (idx < ev.size()) begin
            if (hs[idx] && !v) begin
               exp       = '0;
               exp.ready = 1'b1;
            end else begin
               exp = ev[idx];
               idx++;
            end
         end else begin
            exp      = '0;
            exp.endo = 1'b1;
            t_end    = off;
            fin      = 1'b1;
         end
         exp.cv    = prev_ciph;
         prev_ciph = exp.ciph;
         @(negedge clk);
         check_out($sformatf("cyc%0d", off), dut_o, exp);
         if (off < 256) tr[off] = dut_o;
         if (off == abort_off) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            check_out("abort_reset", dut_o, '0);
            rst_n     = 1'b1;
            prev_ciph = 1'b0;
            in_done   = 1'b0;
            start     = 1'b0;
            return;
         end
         if (off >= 2000) begin
            check_val("timeout", 32'(off), 32'(0));
            fin = 1'b1;
         end
      end
      start   = 1'b0;
      in_done = 1'b1;
   endtask

   initial begin
      int   t_end;
      out_t g;
      build_events();
      vecs = '{
         '{1,  4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
         '{2,  4'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
         '{12, 4'd11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
         '{13, 4'd6,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
         '{18, 4'd11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
         '{19, 4'd6,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
         '{20, 4'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
         '{21, 4'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
         '{26, 4'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
         '{31, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
         '{32, 4'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
         '{42, 4'd11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
         '{43, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
         '{44, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}
      };

      #12;
      check_out("reset_state", dut_o, '0);
      #10 rst_n = 1'b1;

      run_enc(100, 0, -1, 1'b0, t_end);
      check_val("nominal_end", 32'(t_end), 32'd44);
      foreach (vecs[i]) begin
         g = tr[vecs[i].off];
         check_val($sformatf("table_t%0d", vecs[i].off),
                   32'({g.rnd, g.mode, g.ready, g.ke, g.lsb, g.kb, g.cv, g.tag, g.endo}),
                   32'({vecs[i].rnd, vecs[i].mode, vecs[i].ready, vecs[i].ke, vecs[i].lsb,
                        vecs[i].kb, vecs[i].cv, vecs[i].tag, vecs[i].endo}));
      end

      run_enc(100, 5, -1, 1'b0, t_end);
      check_val("hold_ad_end", 32'(t_end), 32'd49);
      for (int k = 13; k < 18; k++) begin
         g = tr[k];
         check_val($sformatf("hold_ad_t%0d", k),
                   32'({g.ready, g.rnd, g.en_reg}), 32'({1'b1, 4'd0, 1'b0}));
      end

      run_enc(100, 0, 36, 1'b0, t_end);
      run_enc(100, 0, -1, 1'b0, t_end);
      check_val("after_abort_end", 32'(t_end), 32'd44);

      for (int n = 0; n < 20; n++) begin
         run_enc(int'($urandom_range(100, 40)), int'($urandom_range(3)), -1, 1'b1, t_end);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/ascon_fsm.md
# ascon_fsm

Control unit for the ASCON-128 encryption datapath: permutation core, begin/end XOR stages, state register, cipher and tag registers. It sequences the fixed message format of one associated-data block A and three plaintext blocks P1..P3. The sequence is initialisation (p12), AD (p6), P1/P2 (p6), P3 plus finalisation (p12), and tag capture. The core executes one round per clock; this block drives the round index, all enables and mux selects, and a ready/valid handshake toward the data source.

## Interface
- No parameters.
- clock_i  in  1  system clock, rising edge
- resetb_i  in  1  reset, asynchronous, active-low
- start_i  in  1  launch one encryption; accepted in IDLE or DONE
- data_valid_i  in  1  data_i on the core holds the current block (A, P1, P2, P3)
- data_ready_o  out  1  controller waits for a block
- round_o  out  4  round index to the core, 0..11
- state_mode_o  out  1  0: core takes external state_i (IV‖K‖N); 1: state register loop
- en_reg_state_o  out  1  state register write enable
- en_xor_data_o  out  1  XOR data_i into state word 0 before the round
- en_xor_key_begin_o  out  1  XOR key into words 1–2 before the round
- en_xor_key_end_o  out  1  XOR key into words 3–4 after the round
- en_xor_lsb_o  out  1  XOR domain-separation bit into the LSB of word 4 after the round
- en_cipher_o  out  1  cipher register load
- en_tag_o  out  1  tag register load
- cipher_valid_o  out  1  one-cycle pulse; cipher_o holds a new block
- end_o  out  1  tag_o valid; encryption finished

## Operation
- States:
  - IDLE
  - INIT: rounds 0..11
  - WAIT_AD
  - AD: rounds 7..11
  - WAIT_PT
  - PT: rounds 7..11
  - FINAL: rounds 1..11
  - TAG
  - DONE
- Block counter, 2 bits: 0..2, selects P1/P2/P3.
- In every state not listed below, all outputs are 0.
- IDLE/DONE + start_i → INIT at round 0.
  - The first INIT cycle drives state_mode_o=0; all other round cycles drive 1.
  - The block counter clears.
- INIT: en_reg_state_o=1 every cycle. Round 11 adds en_xor_key_end_o=1. → WAIT_AD.
- WAIT_AD: data_ready_o=1 and en_reg_state_o=0 until data_valid_i.
  - Handshake cycle = round 6, with en_xor_data_o=1 and en_reg_state_o=1. → AD.
  - AD, round 11: en_xor_lsb_o=1. → WAIT_PT.
- WAIT_PT: data_ready_o=1 until data_valid_i. The handshake cycle drives en_xor_data_o=1, en_cipher_o=1 and en_reg_state_o=1.
  - Block counter 0 or 1: round 6 → PT. At PT round 11, counter+1 → WAIT_PT.
  - Block counter 2: round 0 plus en_xor_key_begin_o=1 → FINAL.
- FINAL: round 11 adds en_xor_key_end_o=1. → TAG.
- TAG: en_tag_o=1 for one cycle. → DONE.
- DONE: end_o=1, held until start_i.
- start_i is ignored outside IDLE/DONE.
- data_valid_i is ignored outside WAIT_AD/WAIT_PT.
- round_o is 0 in all non-round states.

## Timing
- Reset: state IDLE, counters 0, every output 0. Reset mid-operation aborts to IDLE. Only a new start_i restarts the sequence.
- Every round takes exactly one cycle. The handshake cycle is itself the first round of its phase.
- cipher_valid_o = en_cipher_o registered by one cycle, so it aligns with cipher_o.
- en_tag_o fires one cycle after the last FINAL round, once the state register holds the result. end_o follows one cycle later.
- Latency with data_valid_i always 1 and start_i at cycle t:
  - INIT t+1..t+12
  - AD t+13..t+18
  - P1 t+19..t+24
  - P2 t+25..t+30
  - FINAL t+31..t+42
  - TAG t+43
  - end_o rises at t+44
- Each cycle that data_valid_i is withheld adds one cycle to this latency.
- start_i asserted in DONE drops end_o on the next cycle.

## Structure
- In ascon_pack:
  - typedef enum fsm_state_t
  - constants ROUND_P12_FIRST=0, ROUND_P6_FIRST=6, ROUND_LAST=11, NB_PT_BLOCKS=3
- Sub-module round_counter:
  - 4-bit counter with synchronous load (0 or 6) and increment enable
  - output last_o = (count == 11)
  - same clock_i/resetb_i
- FSM next-state and output logic: one combinational process plus a state register.

## Test plan
- Reset during FINAL, round 5 → next cycle all outputs 0 and state IDLE. A new start_i gives an INIT sequence with round_o 0..11.
- start_i with data_valid_i constantly 1:
  - round_o runs 0..11, 6..11 ×3, 0..11
  - en_xor_key_end_o pulses at t+12 and t+42
  - en_xor_lsb_o at t+18
  - end_o at t+44
- data_valid_i held low 5 cycles in WAIT_AD → data_ready_o high 5 cycles, round_o=0, en_reg_state_o=0. end_o moves to t+49.
- Full run against the core with the ASCON-128 known-answer vector (K, N, A, P1..P3) → cipher_o and tag_o match the reference C1..C3 and T.
- cipher_valid_o pulses at t+20, t+26, t+32, single-cycle.
- start_i during PT is ignored; start_i in DONE restarts with end_o cleared at the next cycle.
